// File: rtl/pipelined_carry_adder_pkg.sv
// Shared constants and helpers for the segmented, pipelined carry adder.
package pipelined_carry_adder_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_SEG   = 4;

  // Saturation limit for a width-bit two's-complement result:
  // the most negative value when neg=1, the most positive otherwise.
  function automatic logic [63:0] sat_limit(input logic neg, input int width);
    logic [63:0] msb;
    msb = 64'd1 << (width - 1);
    return neg ? msb : (msb - 64'd1);
  endfunction

endpackage

// File: rtl/adder_segment.sv
// One registered SEG-bit slice of the carry chain; holds its outputs while en is low.
module adder_segment
  import pipelined_carry_adder_pkg::*;
#(
  parameter int SEG = DEFAULT_SEG
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  input  logic           vin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           vout
);

  logic [SEG:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};

  always_ff @(posedge clk) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
      vout <= 1'b0;
    end else if (en) begin
      sum  <= total[SEG-1:0];
      cout <= total[SEG];
      vout <= vin;
    end
  end

endmodule

// File: rtl/pipelined_carry_adder.sv
// Add/subtract split into SEG-bit stages with a registered carry between stages;
// operands are skewed in and sum segments deskewed out so each result emerges whole.
module pipelined_carry_adder
  import pipelined_carry_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SEG   = DEFAULT_SEG,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = WIDTH / SEG;
  localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(sat_limit(1'b0, WIDTH));
  localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(sat_limit(1'b1, WIDTH));

  if (SEG < 1 || SEG > WIDTH || (WIDTH % SEG) != 0) begin : g_bad_params
    $error("pipelined_carry_adder: SEG must divide WIDTH and lie in 1..WIDTH");
  end

  // Handshake: a transfer happens on any edge where valid && ready are both high.
  // The whole pipeline moves as one (advance) whenever the output slot is empty
  // or being drained; otherwise every register holds, so outputs stay stable.
  logic             advance;
  logic [WIDTH-1:0] bp;
  logic [WIDTH-1:0] sum_raw;
  logic [NSEG-1:0]  stg_cin;
  logic [NSEG-1:0]  stg_vin;
  logic [NSEG-1:0]  stg_c;
  logic [NSEG-1:0]  stg_v;
  logic [SEG-1:0]   stg_a   [NSEG];
  logic [SEG-1:0]   stg_b   [NSEG];
  logic [SEG-1:0]   stg_sum [NSEG];
  logic             a_msb_q;
  logic             b_msb_q;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !rst;
  assign bp       = sub ? ~b : b;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign stg_a[k]   = a[k*SEG +: SEG];
      assign stg_b[k]   = bp[k*SEG +: SEG];
      assign stg_cin[k] = sub;
      assign stg_vin[k] = in_valid && in_ready;
    end else begin : g_skew
      // Segment k waits k cycles so it meets the carry of its own transaction.
      logic [SEG-1:0] a_dl [k];
      logic [SEG-1:0] b_dl [k];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < k; i++) begin
            a_dl[i] <= '0;
            b_dl[i] <= '0;
          end
        end else if (advance) begin
          a_dl[0] <= a[k*SEG +: SEG];
          b_dl[0] <= bp[k*SEG +: SEG];
          for (int i = 1; i < k; i++) begin
            a_dl[i] <= a_dl[i-1];
            b_dl[i] <= b_dl[i-1];
          end
        end
      end

      assign stg_a[k]   = a_dl[k-1];
      assign stg_b[k]   = b_dl[k-1];
      assign stg_cin[k] = stg_c[k-1];
      assign stg_vin[k] = stg_v[k-1];
    end

    adder_segment #(.SEG(SEG)) u_seg (
      .clk  (clk),
      .rst  (rst),
      .en   (advance),
      .a    (stg_a[k]),
      .b    (stg_b[k]),
      .cin  (stg_cin[k]),
      .vin  (stg_vin[k]),
      .sum  (stg_sum[k]),
      .cout (stg_c[k]),
      .vout (stg_v[k])
    );

    if (k == NSEG - 1) begin : g_last
      assign sum_raw[k*SEG +: SEG] = stg_sum[k];
    end else begin : g_deskew
      localparam int D = NSEG - 1 - k;
      logic [SEG-1:0] s_dl [D];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < D; i++) s_dl[i] <= '0;
        end else if (advance) begin
          s_dl[0] <= stg_sum[k];
          for (int i = 1; i < D; i++) s_dl[i] <= s_dl[i-1];
        end
      end

      assign sum_raw[k*SEG +: SEG] = s_dl[D-1];
    end
  end

  // Operand sign bits travel alongside the final stage for the overflow decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else if (advance) begin
      a_msb_q <= stg_a[NSEG-1][SEG-1];
      b_msb_q <= stg_b[NSEG-1][SEG-1];
    end
  end

  assign out_valid = stg_v[NSEG-1];
  assign cout      = stg_c[NSEG-1];
  assign ovf       = (a_msb_q == b_msb_q) && (sum_raw[WIDTH-1] != a_msb_q);
  assign sum       = (SAT && ovf) ? (a_msb_q ? SAT_NEG : SAT_POS) : sum_raw;

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Directed bench: main 16/4 wrapping instance plus saturating, single-stage and
// bit-serial variants sharing a second stimulus port set.
module tb_pipelined_carry_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // main instance (WIDTH=16, SEG=4, SAT=0)
  logic        in_valid = 1'b0, out_ready = 1'b1, sub = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        in_ready, out_valid, cout, ovf;
  logic [15:0] sum;

  // shared stimulus for the three variants
  logic        in_valid2 = 1'b0, out_ready2 = 1'b1, sub2 = 1'b0;
  logic [15:0] a2 = '0, b2 = '0;
  logic        ir_sat, ov_sat, c_sat, o_sat;
  logic        ir_16, ov_16, c_16, o_16;
  logic        ir_1, ov_1, c_1, o_1;
  logic [15:0] s_sat, s_16, s_1;

  pipelined_carry_adder #(.WIDTH(16), .SEG(4), .SAT(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipelined_carry_adder #(.WIDTH(16), .SEG(4), .SAT(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(ir_sat), .a(a2), .b(b2),
    .sub(sub2), .out_valid(ov_sat), .out_ready(out_ready2), .sum(s_sat), .cout(c_sat), .ovf(o_sat)
  );

  pipelined_carry_adder #(.WIDTH(16), .SEG(16), .SAT(1'b0)) dut_s16 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(ir_16), .a(a2), .b(b2),
    .sub(sub2), .out_valid(ov_16), .out_ready(out_ready2), .sum(s_16), .cout(c_16), .ovf(o_16)
  );

  pipelined_carry_adder #(.WIDTH(16), .SEG(1), .SAT(1'b0)) dut_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(ir_1), .a(a2), .b(b2),
    .sub(sub2), .out_valid(ov_1), .out_ready(out_ready2), .sum(s_1), .cout(c_1), .ovf(o_1)
  );

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_q[$];

  // captured first result of each variant: 0=sat, 1=seg16, 2=seg1
  int          cap_l [3];
  logic [15:0] cap_s [3];
  logic        cap_c [3];
  logic        cap_o [3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send1(input logic [15:0] ta, input logic [15:0] tb, input logic ts,
                       output int lat, output logic [15:0] rs, output logic rc, output logic ro);
    out_ready = 1'b1;
    a = ta; b = tb; sub = ts; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (!out_valid) lat = -1;
    rs = sum; rc = cout; ro = ovf;
    tick();
  endtask

  task automatic send2(input logic [15:0] ta, input logic [15:0] tb, input logic ts);
    out_ready2 = 1'b1;
    a2 = ta; b2 = tb; sub2 = ts; in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cap_l[i] = -1; cap_s[i] = '0; cap_c[i] = 1'b0; cap_o[i] = 1'b0;
    end
    for (int c = 1; c <= 20; c++) begin
      if (ov_sat && cap_l[0] < 0) begin cap_l[0] = c; cap_s[0] = s_sat; cap_c[0] = c_sat; cap_o[0] = o_sat; end
      if (ov_16  && cap_l[1] < 0) begin cap_l[1] = c; cap_s[1] = s_16;  cap_c[1] = c_16;  cap_o[1] = o_16;  end
      if (ov_1   && cap_l[2] < 0) begin cap_l[2] = c; cap_s[2] = s_1;   cap_c[2] = c_1;   cap_o[2] = o_1;   end
      tick();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1; a = 16'hFFFF; b = 16'h0001;
    in_valid2 = 1'b1; a2 = 16'h7FFF; b2 = 16'h0001;
    repeat (3) tick();
    checks += 6;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    if (sum !== 16'h0000)   begin failures++; $display("FAIL reset_sum: got %h want 0000", sum); end
    if (cout !== 1'b0)      begin failures++; $display("FAIL reset_cout: got %b want 0", cout); end
    if (ovf !== 1'b0)       begin failures++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    if (in_ready !== 1'b0)  begin failures++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    if ({ov_sat, ov_16, ov_1} !== 3'b000) begin
      failures++; $display("FAIL reset_variant_valid: got %b want 000", {ov_sat, ov_16, ov_1});
    end
    in_valid = 1'b0; in_valid2 = 1'b0;
    rst = 1'b0;
    #1;
    checks += 2;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    if ({ir_sat, ir_16, ir_1} !== 3'b111) begin
      failures++; $display("FAIL release_variant_ready: got %b want 111", {ir_sat, ir_16, ir_1});
    end
    tick();
  endtask

  task automatic test_carry_wrap();
    int lat; logic [15:0] rs; logic rc, ro;
    send1(16'hFFFF, 16'h0001, 1'b0, lat, rs, rc, ro);
    checks += 4;
    if (lat !== 4)       begin failures++; $display("FAIL carry_latency: got %0d want 4", lat); end
    if (rs !== 16'h0000) begin failures++; $display("FAIL carry_sum: got %h want 0000", rs); end
    if (rc !== 1'b1)     begin failures++; $display("FAIL carry_cout: got %b want 1", rc); end
    if (ro !== 1'b0)     begin failures++; $display("FAIL carry_ovf: got %b want 0", ro); end
    send1(16'h0FFF, 16'h0001, 1'b0, lat, rs, rc, ro);
    checks += 2;
    if (rs !== 16'h1000) begin failures++; $display("FAIL ripple_sum: got %h want 1000", rs); end
    if (rc !== 1'b0)     begin failures++; $display("FAIL ripple_cout: got %b want 0", rc); end
  endtask

  task automatic test_overflow_wrap();
    int lat; logic [15:0] rs; logic rc, ro;
    send1(16'h7FFF, 16'h0001, 1'b0, lat, rs, rc, ro);
    checks += 3;
    if (rs !== 16'h8000) begin failures++; $display("FAIL ovf_pos_sum: got %h want 8000", rs); end
    if (ro !== 1'b1)     begin failures++; $display("FAIL ovf_pos_flag: got %b want 1", ro); end
    if (rc !== 1'b0)     begin failures++; $display("FAIL ovf_pos_cout: got %b want 0", rc); end
    send1(16'h8000, 16'h8000, 1'b0, lat, rs, rc, ro);
    checks += 3;
    if (rs !== 16'h0000) begin failures++; $display("FAIL ovf_neg_sum: got %h want 0000", rs); end
    if (ro !== 1'b1)     begin failures++; $display("FAIL ovf_neg_flag: got %b want 1", ro); end
    if (rc !== 1'b1)     begin failures++; $display("FAIL ovf_neg_cout: got %b want 1", rc); end
  endtask

  task automatic test_subtract();
    int lat; logic [15:0] rs; logic rc, ro;
    send1(16'h0003, 16'h0005, 1'b1, lat, rs, rc, ro);
    checks += 3;
    if (rs !== 16'hFFFE) begin failures++; $display("FAIL sub_borrow_sum: got %h want fffe", rs); end
    if (rc !== 1'b0)     begin failures++; $display("FAIL sub_borrow_cout: got %b want 0", rc); end
    if (ro !== 1'b0)     begin failures++; $display("FAIL sub_borrow_ovf: got %b want 0", ro); end
    send1(16'h0005, 16'h0003, 1'b1, lat, rs, rc, ro);
    checks += 2;
    if (rs !== 16'h0002) begin failures++; $display("FAIL sub_pos_sum: got %h want 0002", rs); end
    if (rc !== 1'b1)     begin failures++; $display("FAIL sub_pos_cout: got %b want 1", rc); end
    send1(16'h0000, 16'h0000, 1'b1, lat, rs, rc, ro);
    checks += 2;
    if (rs !== 16'h0000) begin failures++; $display("FAIL sub_zero_sum: got %h want 0000", rs); end
    if (rc !== 1'b1)     begin failures++; $display("FAIL sub_zero_cout: got %b want 1", rc); end
  endtask

  task automatic test_variants();
    logic [15:0] va   [6] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h1234, 16'h0FFF, 16'hFFFF};
    logic [15:0] vb   [6] = '{16'h0001, 16'h0001, 16'hFFFF, 16'h4321, 16'h0001, 16'h0001};
    logic        vsub [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [15:0] vwr  [6] = '{16'h8000, 16'h7FFF, 16'h8000, 16'h5555, 16'h1000, 16'h0000};
    logic [15:0] vst  [6] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h5555, 16'h1000, 16'h0000};
    logic        vc   [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        vo   [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int          vlat [3] = '{4, 1, 16};
    for (int t = 0; t < 6; t++) begin
      send2(va[t], vb[t], vsub[t]);
      checks += 1;
      if (cap_s[0] !== vst[t]) begin
        failures++; $display("FAIL sat_sum[%0d]: got %h want %h", t, cap_s[0], vst[t]);
      end
      for (int d = 0; d < 3; d++) begin
        checks += 3;
        if (cap_l[d] !== vlat[d]) begin
          failures++; $display("FAIL variant%0d_latency[%0d]: got %0d want %0d", d, t, cap_l[d], vlat[d]);
        end
        if (cap_c[d] !== vc[t]) begin
          failures++; $display("FAIL variant%0d_cout[%0d]: got %b want %b", d, t, cap_c[d], vc[t]);
        end
        if (cap_o[d] !== vo[t]) begin
          failures++; $display("FAIL variant%0d_ovf[%0d]: got %b want %b", d, t, cap_o[d], vo[t]);
        end
        if (d != 0) begin
          checks += 1;
          if (cap_s[d] !== vwr[t]) begin
            failures++; $display("FAIL variant%0d_sum[%0d]: got %h want %h", d, t, cap_s[d], vwr[t]);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ba [8] = '{16'h0001, 16'h00FF, 16'h0F0F, 16'h1000, 16'hABCD, 16'hFFFF, 16'h8000, 16'h0000};
    logic [15:0] bb [8] = '{16'h0002, 16'h0001, 16'hF0F0, 16'h0001, 16'h1111, 16'hFFFF, 16'h0001, 16'h0001};
    logic        bs [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] be [8] = '{16'h0003, 16'h0100, 16'hFFFF, 16'h0FFF, 16'hBCDE, 16'hFFFE, 16'h7FFF, 16'hFFFF};
    int          idx = 0, got = 0, cyc = 0;
    logic        stall_prev = 1'b0;
    logic [15:0] held = '0, want;
    exp_q.delete();
    out_ready = 1'b0;
    while (got < 8 && cyc < 200) begin
      out_ready = ~out_ready;
      if (idx < 8) begin
        in_valid = 1'b1; a = ba[idx]; b = bb[idx]; sub = bs[idx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stall_prev) begin
        checks++;
        if (out_valid !== 1'b1 || sum !== held) begin
          failures++; $display("FAIL stall_hold: got valid=%b sum=%h want valid=1 sum=%h", out_valid, sum, held);
        end
      end
      checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        failures++; $display("FAIL b2b_in_ready: got %b with out_valid=%b out_ready=%b", in_ready, out_valid, out_ready);
      end
      if (out_valid && out_ready) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        checks++;
        if (sum !== want) begin
          failures++; $display("FAIL b2b_result[%0d]: got %h want %h", got, sum, want);
        end
        got++;
      end
      stall_prev = out_valid && !out_ready;
      held = sum;
      if (in_valid && in_ready) begin
        exp_q.push_back(be[idx]);
        idx++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks += 2;
    if (got !== 8) begin failures++; $display("FAIL b2b_count: got %0d want 8", got); end
    if (exp_q.size() !== 0) begin failures++; $display("FAIL b2b_leftover: got %0d want 0", exp_q.size()); end
    repeat (6) tick();
  endtask

  task automatic test_reset_in_flight();
    int seen = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 16'h0100 * 16'(i + 1); b = 16'h0001; sub = 1'b0; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    repeat (12) begin
      tick();
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL flush_ghost_results: got %0d want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_carry_wrap();
    test_overflow_wrap();
    test_subtract();
    test_variants();
    test_back_to_back();
    test_reset_in_flight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
